// File: rtl/pc_seq_ctrl_if.sv
// rtl/pc_seq_ctrl_if.sv - PC sequencer redirect/stall bus
// slave = sequencer side, master = pipeline/stimulus side.
interface pc_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [31:0]      F_PC;
  logic [1:0]       D_npc_sel;
  logic             D_br_taken;
  logic [31:0]      D_br_target;
  logic [31:0]      D_j_target;
  logic [31:0]      D_jr_target;
  logic             D_hazard_stall;
  logic             D_md_use;
  logic             E_md_start;
  logic             E_md_is_div;
  logic [31:0]      F_newPC;
  logic             F_en;
  logic             D_en;
  logic             E_clr;
  logic             md_busy;
  logic [CNT_W-1:0] md_cnt;
  logic             F_adel;

  modport master (
    output F_PC, D_npc_sel, D_br_taken, D_br_target, D_j_target, D_jr_target,
           D_hazard_stall, D_md_use, E_md_start, E_md_is_div,
    input  F_newPC, F_en, D_en, E_clr, md_busy, md_cnt, F_adel
  );

  modport slave (
    input  F_PC, D_npc_sel, D_br_taken, D_br_target, D_j_target, D_jr_target,
           D_hazard_stall, D_md_use, E_md_start, E_md_is_div,
    output F_newPC, F_en, D_en, E_clr, md_busy, md_cnt, F_adel
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - F-stage next-PC sequencer with mult/div busy stall
// Optional macro PC_ALIGN_CHK_EN enables the sticky illegal-PC flag F_adel.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC,
  parameter int          MULT_CYC = 5,
  parameter int          DIV_CYC  = 10,
  parameter int          CNT_W    = 4
) (
  input  logic          clk,
  input  logic          reset,
  pc_seq_ctrl_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] md_cnt_q;
  logic             md_busy;
  logic             stall;
  logic [31:0]      pc_plus4;
  logic [31:0]      new_pc;

  if (MULT_CYC < 1 || DIV_CYC < 1 || PC_HI < RESET_PC ||
      MULT_CYC >= (1 << CNT_W) || DIV_CYC >= (1 << CNT_W)) begin : g_bad_cfg
    $error("pc_seq_ctrl: inconsistent parameters");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.E_md_start) begin
          md_cnt_q <= bus.E_md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
          state_q  <= BUSY;
        end
        // A start arriving while busy is a protocol violation and is dropped.
        BUSY: if (md_cnt_q == CNT_W'(1)) begin
          md_cnt_q <= '0;
          state_q  <= IDLE;
        end else begin
          md_cnt_q <= md_cnt_q - CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    md_busy  = bus.E_md_start | (state_q == BUSY);
    stall    = bus.D_hazard_stall | (bus.D_md_use & md_busy);
    pc_plus4 = bus.F_PC + 32'd4;
    new_pc   = bus.F_PC;
    if (!stall) begin
      case (bus.D_npc_sel)
        2'b00:   new_pc = pc_plus4;
        2'b01:   new_pc = bus.D_br_taken ? bus.D_br_target : pc_plus4;
        2'b10:   new_pc = bus.D_j_target;
        default: new_pc = bus.D_jr_target;
      endcase
    end
  end

  assign bus.F_newPC = new_pc;
  assign bus.F_en    = ~stall;
  assign bus.D_en    = ~stall;
  assign bus.E_clr   = stall;
  assign bus.md_busy = md_busy;
  assign bus.md_cnt  = md_cnt_q;

`ifdef PC_ALIGN_CHK_EN
  logic f_adel_q;
  logic f_adel_d;

  always_comb begin
    f_adel_d = f_adel_q;
    if (!stall && ((new_pc[1:0] != 2'b00) || (new_pc < RESET_PC) || (new_pc > PC_HI)))
      f_adel_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) f_adel_q <= 1'b0;
    else        f_adel_q <= f_adel_d;
  end

  assign bus.F_adel = f_adel_q;
`else
  assign bus.F_adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - directed bench with cycle-level reference model
module tb_pc_seq_ctrl;
  localparam int          MULT = 5;
  localparam int          DIV  = 10;
  localparam logic [31:0] LO   = 32'h0000_3000;
  localparam logic [31:0] HI   = 32'h0000_6FFC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_seq_ctrl_if #(.CNT_W(4)) bus ();
  pc_seq_ctrl #(.RESET_PC(LO), .PC_HI(HI), .MULT_CYC(MULT), .DIV_CYC(DIV), .CNT_W(4))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;
`ifdef PC_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Reference model: remaining busy cycles of the md unit and the sticky flag.
  int rem    = 0;
  bit m_adel = 1'b0;

  function automatic bit m_busy();
    return bus.E_md_start || (rem > 0);
  endfunction

  function automatic bit m_stall();
    return bus.D_hazard_stall || (bus.D_md_use && m_busy());
  endfunction

  function automatic logic [31:0] m_newpc();
    if (m_stall()) return bus.F_PC;
    case (bus.D_npc_sel)
      2'd0: return bus.F_PC + 32'd4;
      2'd1: return bus.D_br_taken ? bus.D_br_target : bus.F_PC + 32'd4;
      2'd2: return bus.D_j_target;
      default: return bus.D_jr_target;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem = 0;
      m_adel = 1'b0;
    end else begin
      logic [31:0] np;
      np = m_newpc();
      if (CHK && !m_stall() && (np % 4 != 0 || np < LO || np > HI)) m_adel = 1'b1;
      if (rem == 0) begin
        if (bus.E_md_start) rem = bus.E_md_is_div ? DIV : MULT;
      end else begin
        rem = rem - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_newpc",  bus.F_newPC, m_newpc());
      chk("cyc_f_en",   32'(bus.F_en),    32'(!m_stall()));
      chk("cyc_d_en",   32'(bus.D_en),    32'(!m_stall()));
      chk("cyc_e_clr",  32'(bus.E_clr),   32'(m_stall()));
      chk("cyc_busy",   32'(bus.md_busy), 32'(m_busy()));
      chk("cyc_md_cnt", 32'(bus.md_cnt),  32'(rem));
      chk("cyc_adel",   32'(bus.F_adel),  32'(m_adel));
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  int st, bz, fz;
  logic [3:0] mc [0:19];

  initial begin
    bus.F_PC = LO; bus.D_npc_sel = 2'd0; bus.D_br_taken = 1'b0;
    bus.D_br_target = '0; bus.D_j_target = '0; bus.D_jr_target = '0;
    bus.D_hazard_stall = 1'b0; bus.D_md_use = 1'b0;
    bus.E_md_start = 1'b0; bus.E_md_is_div = 1'b0;
    next(); next();
    reset = 1'b1;
    cmp_en = 1'b1;

    // Reset in the middle of a mult busy window
    next(); bus.E_md_start = 1'b1;
    next(); bus.E_md_start = 1'b0; bus.D_md_use = 1'b1;
    next(); next();
    reset = 1'b0;
    look();
    chk("rst_md_cnt", 32'(bus.md_cnt), 32'd0);
    chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_adel", 32'(bus.F_adel), 32'd0);
    next(); reset = 1'b1;
    look();
    chk("rel_newpc", bus.F_newPC, 32'h0000_3004);
    chk("rel_f_en", 32'(bus.F_en), 32'd1);
    next(); bus.D_md_use = 1'b0;

    // Mult with a dependent consumer held in D
    bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b0; bus.D_md_use = 1'b1;
    st = 0;
    for (int i = 0; i < 20; i++) begin
      look();
      mc[i] = bus.md_cnt;
      if (bus.E_clr) st++;
      next(); bus.E_md_start = 1'b0;
    end
    chk("mult_stall_cycles", 32'(st), 32'd6);
    chk("mult_cnt_1", 32'(mc[1]), 32'd5);
    chk("mult_cnt_5", 32'(mc[5]), 32'd1);
    chk("mult_cnt_6", 32'(mc[6]), 32'd0);
    bus.D_md_use = 1'b0;

    // Div with no consumer: busy 11 cycles, no stall
    bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b1;
    bz = 0; fz = 0;
    for (int i = 0; i < 20; i++) begin
      look();
      if (bus.md_busy) bz++;
      if (!bus.F_en) fz++;
      next(); bus.E_md_start = 1'b0;
    end
    chk("div_busy_cycles", 32'(bz), 32'd11);
    chk("div_no_stall", 32'(fz), 32'd0);

    // Div followed by mflo: stalls for the 10 remaining busy cycles
    bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b1;
    st = 0;
    for (int i = 0; i < 20; i++) begin
      look();
      if (bus.E_clr) st++;
      next(); bus.E_md_start = 1'b0; bus.D_md_use = 1'b1;
    end
    chk("div_mflo_stall", 32'(st), 32'd10);
    bus.D_md_use = 1'b0;

    // Branch / jump / hazard precedence
    bus.F_PC = LO; bus.D_npc_sel = 2'd1; bus.D_br_taken = 1'b1; bus.D_br_target = 32'h0000_3100;
    look(); chk("br_taken", bus.F_newPC, 32'h0000_3100);
    next(); bus.D_br_taken = 1'b0;
    look(); chk("br_not_taken", bus.F_newPC, 32'h0000_3004);
    next(); bus.D_hazard_stall = 1'b1;
    look(); chk("hz_newpc", bus.F_newPC, 32'h0000_3000);
    chk("hz_f_en", 32'(bus.F_en), 32'd0);
    next(); bus.D_npc_sel = 2'd2; bus.D_j_target = 32'h0000_3200;
    look(); chk("j_under_stall", bus.F_newPC, 32'h0000_3000);
    next(); bus.D_hazard_stall = 1'b0;
    look(); chk("j_target", bus.F_newPC, 32'h0000_3200);

    // jr to the top of the address space, then PC+4 wrap
    next(); bus.D_npc_sel = 2'd3; bus.D_jr_target = 32'hFFFF_FFFC;
    look(); chk("jr_target", bus.F_newPC, 32'hFFFF_FFFC);
    next(); bus.F_PC = 32'hFFFF_FFFC; bus.D_npc_sel = 2'd0;
    look(); chk("pc_wrap", bus.F_newPC, 32'h0000_0000);
    chk("adel_after_high", 32'(bus.F_adel), 32'(CHK));

    // Misaligned jr target and stickiness of the flag
    next(); reset = 1'b0;
    look(); chk("adel_reset", 32'(bus.F_adel), 32'd0);
    next(); reset = 1'b1; bus.F_PC = LO; bus.D_npc_sel = 2'd3; bus.D_jr_target = 32'h0000_3002;
    look(); chk("adel_before_edge", 32'(bus.F_adel), 32'd0);
    next(); bus.F_PC = 32'h0000_3004; bus.D_npc_sel = 2'd0;
    look(); chk("adel_set", 32'(bus.F_adel), 32'(CHK));
    next(); next(); next();
    look(); chk("adel_sticky", 32'(bus.F_adel), 32'(CHK));
    next(); reset = 1'b0;
    look(); chk("adel_cleared", 32'(bus.F_adel), 32'd0);
    next(); reset = 1'b1;
    next();
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
